// File: rtl/exe_divider_pkg.sv
// Shared constants and types for the EXE-stage RV32M divider.
package exe_divider_pkg;

   localparam int WORD_WIDTH   = 32;
   localparam int REGFILE_BITS = 5;
   localparam int CNT_BITS     = 6;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/exe_divider_core.sv
// Unsigned restoring divider iterator: one quotient bit per step, count runs WIDTH-1 down to 0.
// Exposes the next-step quotient/remainder so the caller can register the final result directly.
module div_core_unsigned #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] quot_nxt,
   output logic [WIDTH-1:0] rem_nxt
);

   // A restored remainder is always below the divisor, so it fits WIDTH bits;
   // the extra bit only exists in the shifted/trial values.
   logic [WIDTH-1:0] prem;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   always_comb begin
      shifted  = {prem, quot[WIDTH-1]};
      trial    = shifted - {1'b0, dvsr};
      quot_nxt = {quot[WIDTH-2:0], ~trial[WIDTH]};
      rem_nxt  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         prem  <= '0;
         quot  <= '0;
         dvsr  <= '0;
      end else if (start) begin
         count <= CNT_W'(WIDTH - 1);
         prem  <= '0;
         quot  <= dividend;
         dvsr  <= divisor;
      end else if (step) begin
         prem <= rem_nxt;
         quot <= quot_nxt;
         if (count != '0) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/exe_divider.sv
// EXE-stage RV32M DIV/DIVU/REM/REMU: 33-cycle latency (1 cycle for special cases with DIV_EARLY_OUT_EN),
// busy stalls the pipeline while an op is accepted or calculating; kill aborts an op in CALC.
module exe_divider
   import exe_divider_pkg::*;
#(
   parameter int WIDTH   = WORD_WIDTH,
   parameter int RD_BITS = REGFILE_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               kill,
   input  logic               div_valid,
   input  logic [1:0]         div_op,
   input  logic [WIDTH-1:0]   opA,
   input  logic [WIDTH-1:0]   opB,
   input  logic [RD_BITS-1:0] rd,
   output logic               busy,
   output logic               result_valid,
   output logic [WIDTH-1:0]   result,
   output logic [RD_BITS-1:0] result_rd
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t          state, state_nxt;
   logic                accept, early, is_signed, is_rem, a_neg, b_neg, spc_hit;
   logic [WIDTH-1:0]    mag_a, mag_b, spc_val;
   logic [1:0]          op_r;
   logic [RD_BITS-1:0]  rd_r;
   logic                neg_q_r, neg_r_r, spc_r, is_rem_r;
   logic [WIDTH-1:0]    spc_val_r;
   logic [CNT_BITS-1:0] count;
   logic [WIDTH-1:0]    quot_nxt, rem_nxt, raw, fixed;

   assign accept    = (state == ST_IDLE) && div_valid && !kill;
   assign is_signed = (div_op == DIV_OP_DIV) || (div_op == DIV_OP_REM);
   assign is_rem    = (div_op == DIV_OP_REM) || (div_op == DIV_OP_REMU);
   assign a_neg     = is_signed && opA[WIDTH-1];
   assign b_neg     = is_signed && opB[WIDTH-1];
   assign mag_a     = a_neg ? -opA : opA;
   assign mag_b     = b_neg ? -opB : opB;
   assign is_rem_r  = (op_r == DIV_OP_REM) || (op_r == DIV_OP_REMU);

   // Results the iterator cannot produce correctly are fixed at accept time.
   always_comb begin
      spc_hit = 1'b0;
      spc_val = '0;
      if (opB == '0) begin
         spc_hit = 1'b1;
         spc_val = is_rem ? opA : '1;
      end else if (is_signed && (opA == MIN_NEG) && (opB == '1)) begin
         spc_hit = 1'b1;
         spc_val = is_rem ? '0 : MIN_NEG;
      end
`ifdef DIV_EARLY_OUT_EN
      else if (opA == '0) begin
         spc_hit = 1'b1;
         spc_val = '0;
      end
`endif
   end

`ifdef DIV_EARLY_OUT_EN
   assign early = spc_hit;
`else
   assign early = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               busy      = 1'b1;
               state_nxt = early ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            busy = 1'b1;
            if (kill) begin
               state_nxt = ST_IDLE;
            end else if (count == '0) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      raw   = is_rem_r ? rem_nxt : quot_nxt;
      fixed = (is_rem_r ? neg_r_r : neg_q_r) ? -raw : raw;
   end

   div_core_unsigned #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_BITS)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .start    (accept),
      .step     (state == ST_CALC),
      .dividend (mag_a),
      .divisor  (mag_b),
      .count    (count),
      .quot_nxt (quot_nxt),
      .rem_nxt  (rem_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r      <= '0;
         rd_r      <= '0;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         spc_r     <= 1'b0;
         spc_val_r <= '0;
      end else if (accept) begin
         op_r      <= div_op;
         rd_r      <= rd;
         neg_q_r   <= a_neg ^ b_neg;
         neg_r_r   <= a_neg;
         spc_r     <= spc_hit;
         spc_val_r <= spc_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         result    <= '0;
         result_rd <= '0;
      end else begin
         state <= state_nxt;
         if (accept && early) begin
            result    <= spc_val;
            result_rd <= rd;
         end else if ((state == ST_CALC) && !kill && (count == '0)) begin
            result    <= spc_r ? spc_val_r : fixed;
            result_rd <= rd_r;
         end
      end
   end

   assign result_valid = (state == ST_DONE);

endmodule
